lcd_update_scheduler: RTL and testbench
=======================================

// Module: lcd_update_scheduler
// PURPOSE
//  Sits between the pet game FSM and LCD1602_CONTROLLER and decides when the face/feed/joy/energy
//  inputs change. Latches asynchronous-rate update requests, clamps them and commits them to the
//  controller only on refresh ticks. Enforces a minimum hold of HOLD_TICKS ticks between commits.
//  Drops no-op updates so the LCD is repainted only when content actually changes.
// PARAMETERS
//  NUM_FACES   9  number of face glyphs; face codes 0..NUM_FACES-1
//  MAX_VALUE   5  full-scale bar value for feed/joy/energy
//  HOLD_TICKS  2  minimum ticks between two commits (0 = commit on every tick)
//  DEMO_TICKS  80 ticks per demo step (used only with LCD_SCHED_DEMO_EN)
// PORTS  (FW = $clog2(NUM_FACES), VW = $clog2(MAX_VALUE)+1)
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  tick          in   1   1-cycle refresh strobe (DivisorReloj, ~16 ms)
//  upd_valid     in   1   1-cycle request: sample *_in this cycle
//  face_in       in   FW  requested face code
//  feed_in       in   VW  requested feed level
//  joy_in        in   VW  requested joy level
//  energy_in     in   VW  requested energy level
//  face          out  FW  to controller .face
//  feed_value    out  VW  to controller .feed_value
//  joy_value     out  VW  to controller .joy_value
//  energy_value  out  VW  to controller .energy_value
//  commit        out  1   1-cycle pulse, high in the cycle the new outputs are first visible
//  overwrite     out  1   1-cycle pulse: pending request replaced before it was committed
//  pending       out  1   1 while an uncommitted request is held
//  demo_en       in   1   present only with LCD_SCHED_DEMO_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (synchronous, takes priority over all inputs, including mid-hold or mid-pending):
//    face=0, feed/joy/energy=MAX_VALUE, commit=0, overwrite=0, pending=0, hold_cnt=0, state=IDLE.
//  - Clamping on capture: value > MAX_VALUE -> MAX_VALUE; face >= NUM_FACES -> 0.
//  - States: IDLE (no request held), PEND (request held in pend_* registers).
//  - IDLE: upd_valid -> capture into pend_*, go to PEND. A tick in the same cycle does not commit
//    (minimum latency is capture edge + next tick).
//  - PEND: on tick with hold_cnt==0:
//      pend_* != outputs -> outputs<=pend_*, commit<=1, hold_cnt<=HOLD_TICKS.
//      pend_* == outputs -> no commit, hold_cnt unchanged.
//    In both cases go to IDLE, unless upd_valid is high in the same cycle: the new request is
//    captured and the state stays PEND; overwrite stays 0.
//  - PEND, upd_valid without a committing tick -> replace pend_*, overwrite<=1, stay PEND.
//  - hold_cnt decrements on each tick while nonzero. The commit test uses the pre-decrement value,
//    so with HOLD_TICKS=N the earliest next commit is N+1 ticks after the previous commit.
//  - Outputs, commit and overwrite are registered. commit and overwrite never stay high >1 cycle.
//    pending = (state==PEND).
//  - Outputs never change except on a commit edge or reset.
// CONFIGURATION
//  LCD_SCHED_DEMO_EN defined: adds input demo_en. When demo_en=1, upd_valid is ignored and an
//    internal stepper issues an internal request every DEMO_TICKS ticks. Order: face 0..NUM_FACES-1,
//    then feed 0..MAX, then joy 0..MAX, then energy 0..MAX, then wrap to face 0. Untouched fields
//    hold their last value. These requests obey the same hold/commit rules. Deasserting demo_en
//    freezes the stepper index; reset clears it to 0.
//  LCD_SCHED_DEMO_EN undefined: no demo_en port, no stepper logic; behaviour as above only.
// TESTING  (HOLD_TICKS=2 unless noted; tick every 10 clk)
//  1 reset, then upd face_in=3 feed=2 joy=5 energy=5 -> commit at next tick, face=3 feed=2, pending=0.
//  2 two upd 3 clk apart (face 4, then 6) before a tick -> overwrite pulse once; commit face=6 only.
//  3 commit, then upd every tick -> next commits exactly 3 ticks apart; outputs stable between.
//  4 upd equal to current outputs -> pending clears on tick, no commit pulse; feed_in=7 clamps to 5.
//  5 reset asserted while PEND with hold_cnt=1 -> all outputs to reset values; no commit at next tick.
//  6 (DEMO_EN, DEMO_TICKS=1, HOLD_TICKS=0) demo_en=1 -> face steps 0..8, feed 0..5, joy, energy, wraps.

Source files
------------

// File: rtl/lcd_update_scheduler.sv
// Buffers LCD content update requests and applies them to the controller only on refresh ticks.
// Applies are rate-limited by a hold counter. Define LCD_SCHED_DEMO_EN to add the demo_en stepper.
module lcd_update_scheduler #(
  parameter int unsigned NUM_FACES  = 9,
  parameter int unsigned MAX_VALUE  = 5,
  parameter int unsigned HOLD_TICKS = 2,
  parameter int unsigned DEMO_TICKS = 80,
  localparam int unsigned FW = (NUM_FACES > 1) ? $clog2(NUM_FACES) : 1,
  localparam int unsigned VW = $clog2(MAX_VALUE) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          upd_valid,
  input  logic [FW-1:0] face_in,
  input  logic [VW-1:0] feed_in,
  input  logic [VW-1:0] joy_in,
  input  logic [VW-1:0] energy_in,
`ifdef LCD_SCHED_DEMO_EN
  input  logic          demo_en,
`endif
  output logic [FW-1:0] face,
  output logic [VW-1:0] feed_value,
  output logic [VW-1:0] joy_value,
  output logic [VW-1:0] energy_value,
  output logic          commit,
  output logic          overwrite,
  output logic          pending
);

  localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [FW:0]   FaceLimit = (FW + 1)'(NUM_FACES);
  localparam logic [VW-1:0] MaxVal    = VW'(MAX_VALUE);
  localparam logic [HW-1:0] HoldInit  = HW'(HOLD_TICKS);

  localparam logic StIdle = 1'b0;
  localparam logic StPend = 1'b1;

  function automatic logic [FW-1:0] clamp_face(input logic [FW-1:0] f);
    return ({1'b0, f} >= FaceLimit) ? '0 : f;
  endfunction

  function automatic logic [VW-1:0] clamp_val(input logic [VW-1:0] v);
    return (v > MaxVal) ? MaxVal : v;
  endfunction

  logic          state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [FW-1:0] pend_face_q, pend_face_d, face_q, face_d;
  logic [VW-1:0] pend_feed_q, pend_feed_d, feed_q, feed_d;
  logic [VW-1:0] pend_joy_q, pend_joy_d, joy_q, joy_d;
  logic [VW-1:0] pend_energy_q, pend_energy_d, energy_q, energy_d;
  logic          commit_q, commit_d, overwrite_q, overwrite_d;

  logic          req;
  logic [FW-1:0] req_face;
  logic [VW-1:0] req_feed, req_joy, req_energy;

`ifdef LCD_SCHED_DEMO_EN
  localparam int unsigned DemoSteps = NUM_FACES + 3 * (MAX_VALUE + 1);
  localparam int unsigned DIW = $clog2(DemoSteps);
  localparam int unsigned DTW = (DEMO_TICKS > 1) ? $clog2(DEMO_TICKS) : 1;
  localparam logic [DIW-1:0] DemoLast  = DIW'(DemoSteps - 1);
  localparam logic [DTW-1:0] DemoCntTop = DTW'(DEMO_TICKS - 1);

  logic [DIW-1:0] demo_idx_q;
  logic [DTW-1:0] demo_cnt_q;
  logic [FW-1:0]  demo_face_q, dm_face;
  logic [VW-1:0]  demo_feed_q, demo_joy_q, demo_energy_q, dm_feed, dm_joy, dm_energy;
  logic           demo_fire;
  int unsigned    idx_u;

  assign demo_fire = demo_en && tick && (demo_cnt_q == DemoCntTop);

  // Each step rewrites one field; the others keep the last demo value.
  always_comb begin
    dm_face   = demo_face_q;
    dm_feed   = demo_feed_q;
    dm_joy    = demo_joy_q;
    dm_energy = demo_energy_q;
    idx_u     = 32'(demo_idx_q);
    if (idx_u < NUM_FACES) begin
      dm_face = FW'(idx_u);
    end else if (idx_u < NUM_FACES + MAX_VALUE + 1) begin
      dm_feed = VW'(idx_u - NUM_FACES);
    end else if (idx_u < NUM_FACES + 2 * (MAX_VALUE + 1)) begin
      dm_joy = VW'(idx_u - NUM_FACES - (MAX_VALUE + 1));
    end else begin
      dm_energy = VW'(idx_u - NUM_FACES - 2 * (MAX_VALUE + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      demo_idx_q    <= '0;
      demo_cnt_q    <= '0;
      demo_face_q   <= '0;
      demo_feed_q   <= MaxVal;
      demo_joy_q    <= MaxVal;
      demo_energy_q <= MaxVal;
    end else if (demo_fire) begin
      demo_idx_q    <= (demo_idx_q == DemoLast) ? '0 : demo_idx_q + 1'b1;
      demo_cnt_q    <= '0;
      demo_face_q   <= dm_face;
      demo_feed_q   <= dm_feed;
      demo_joy_q    <= dm_joy;
      demo_energy_q <= dm_energy;
    end else if (demo_en && tick) begin
      demo_cnt_q <= demo_cnt_q + 1'b1;
    end
  end

  assign req        = demo_en ? demo_fire : upd_valid;
  assign req_face   = demo_en ? dm_face   : face_in;
  assign req_feed   = demo_en ? dm_feed   : feed_in;
  assign req_joy    = demo_en ? dm_joy    : joy_in;
  assign req_energy = demo_en ? dm_energy : energy_in;
`else
  logic unused_demo_ticks;
  assign unused_demo_ticks = ^DEMO_TICKS;

  assign req        = upd_valid;
  assign req_face   = face_in;
  assign req_feed   = feed_in;
  assign req_joy    = joy_in;
  assign req_energy = energy_in;
`endif

  logic consume, changed;

  // A tick with the hold expired retires the pending request, whether or not it changes anything.
  assign consume = (state_q == StPend) && tick && (hold_q == '0);
  assign changed = (pend_face_q != face_q) || (pend_feed_q != feed_q) ||
                   (pend_joy_q != joy_q) || (pend_energy_q != energy_q);

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    pend_face_d   = pend_face_q;
    pend_feed_d   = pend_feed_q;
    pend_joy_d    = pend_joy_q;
    pend_energy_d = pend_energy_q;
    face_d        = face_q;
    feed_d        = feed_q;
    joy_d         = joy_q;
    energy_d      = energy_q;
    commit_d      = 1'b0;
    overwrite_d   = 1'b0;

    if (consume && changed) begin
      face_d   = pend_face_q;
      feed_d   = pend_feed_q;
      joy_d    = pend_joy_q;
      energy_d = pend_energy_q;
      commit_d = 1'b1;
      hold_d   = HoldInit;
    end else if (tick && (hold_q != '0)) begin
      hold_d = hold_q - 1'b1;
    end

    if (req) begin
      pend_face_d   = clamp_face(req_face);
      pend_feed_d   = clamp_val(req_feed);
      pend_joy_d    = clamp_val(req_joy);
      pend_energy_d = clamp_val(req_energy);
      state_d       = StPend;
      overwrite_d   = (state_q == StPend) && !consume;
    end else if (consume) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      pend_face_q   <= '0;
      pend_feed_q   <= MaxVal;
      pend_joy_q    <= MaxVal;
      pend_energy_q <= MaxVal;
      face_q        <= '0;
      feed_q        <= MaxVal;
      joy_q         <= MaxVal;
      energy_q      <= MaxVal;
      commit_q      <= 1'b0;
      overwrite_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      pend_face_q   <= pend_face_d;
      pend_feed_q   <= pend_feed_d;
      pend_joy_q    <= pend_joy_d;
      pend_energy_q <= pend_energy_d;
      face_q        <= face_d;
      feed_q        <= feed_d;
      joy_q         <= joy_d;
      energy_q      <= energy_d;
      commit_q      <= commit_d;
      overwrite_q   <= overwrite_d;
    end
  end

  assign face         = face_q;
  assign feed_value   = feed_q;
  assign joy_value    = joy_q;
  assign energy_value = energy_q;
  assign commit       = commit_q;
  assign overwrite    = overwrite_q;
  assign pending      = (state_q == StPend);

endmodule

// File: tb/tb_lcd_update_scheduler.sv
// Scoreboard bench for lcd_update_scheduler: expected commits are queued at request time and
// matched against every commit pulse; outputs are also watched for changes outside commits.
module tb_lcd_update_scheduler;

`ifdef LCD_SCHED_DEMO_EN
  localparam int unsigned Hold = 0;
  localparam int unsigned DemoTicks = 1;
`else
  localparam int unsigned Hold = 2;
  localparam int unsigned DemoTicks = 80;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic upd_valid = 1'b0;
  logic [3:0] face_in = '0, feed_in = '0, joy_in = '0, energy_in = '0;
  logic [3:0] face, feed_value, joy_value, energy_value;
  logic commit, overwrite, pending;
`ifdef LCD_SCHED_DEMO_EN
  logic demo_en = 1'b0;
`endif

  lcd_update_scheduler #(
    .NUM_FACES (9),
    .MAX_VALUE (5),
    .HOLD_TICKS(Hold),
    .DEMO_TICKS(DemoTicks)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .upd_valid   (upd_valid),
    .face_in     (face_in),
    .feed_in     (feed_in),
    .joy_in      (joy_in),
    .energy_in   (energy_in),
`ifdef LCD_SCHED_DEMO_EN
    .demo_en     (demo_en),
`endif
    .face        (face),
    .feed_value  (feed_value),
    .joy_value   (joy_value),
    .energy_value(energy_value),
    .commit      (commit),
    .overwrite   (overwrite),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int phase = 0;
  int tick_count = 0;
  int commit_cnt = 0;
  int ov_cnt = 0;
  logic [15:0] exp_q[$];
  int commit_ticks[$];
  logic [15:0] prev_out = 16'h0555;
  logic prev_commit = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock per call; tick every tenth cycle.
  task automatic step(input bit req, input logic [3:0] f, input logic [3:0] fd,
                      input logic [3:0] j, input logic [3:0] e);
    @(negedge clk);
    phase = (phase == 9) ? 0 : phase + 1;
    tick = (phase == 0);
    if (tick) tick_count++;
    upd_valid = req;
    face_in = f;
    feed_in = fd;
    joy_in = j;
    energy_in = e;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic to_after_tick();
    do idle(1); while (phase != 0);
  endtask

  task automatic wait_commit(input int budget);
    int start = commit_cnt;
    for (int i = 0; i < budget && commit_cnt == start; i++) idle(1);
    if (commit_cnt == start) check("commit_timeout", 32'd0, 32'd1);
  endtask

  // Commit monitor and output stability watch.
  always @(posedge clk) begin
    logic [15:0] cur;
    #1;
    cur = {face, feed_value, joy_value, energy_value};
    if (commit) begin
      commit_cnt++;
      commit_ticks.push_back(tick_count);
      if (exp_q.size() == 0) check("unexpected_commit", {16'd0, cur}, 32'hffff);
      else check("commit_data", {16'd0, cur}, {16'd0, exp_q.pop_front()});
      if (prev_commit) check("commit_pulse_width", 32'd2, 32'd1);
    end
    if (overwrite) ov_cnt++;
    if (!reset && !commit && cur != prev_out) check("out_stable", {16'd0, cur}, {16'd0, prev_out});
    prev_out = cur;
    prev_commit = commit;
  end

  initial begin
    int c0, n;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_face", 32'(face), 32'd0);
    check("rst_feed", 32'(feed_value), 32'd5);
    check("rst_joy_energy", {24'd0, joy_value, energy_value}, 32'h55);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);

`ifdef LCD_SCHED_DEMO_EN
    begin
      logic [3:0] m_f, m_fd, m_j, m_e;
      logic [15:0] m_out, shadow;
      int s;
      m_f = 4'd0; m_fd = 4'd5; m_j = 4'd5; m_e = 4'd5;
      m_out = 16'h0555;
      n = 0;
      for (int idx = 0; idx < 29; idx++) begin
        s = idx % 27;
        if (s < 9) m_f = 4'(s);
        else if (s < 15) m_fd = 4'(s - 9);
        else if (s < 21) m_j = 4'(s - 15);
        else m_e = 4'(s - 21);
        shadow = {m_f, m_fd, m_j, m_e};
        if (shadow != m_out) begin
          exp_q.push_back(shadow);
          m_out = shadow;
          n++;
        end
      end
      c0 = commit_cnt;
      to_after_tick();
      demo_en = 1'b1;
      repeat (29) to_after_tick();
      demo_en = 1'b0;
      to_after_tick();
      to_after_tick();
      check("demo_commits", 32'(commit_cnt - c0), 32'(n));
      check("demo_final_face", 32'(face), 32'd1);
      check("demo_final_energy", 32'(energy_value), 32'd5);
    end
`else
    // Basic request, committed on the following tick.
    to_after_tick();
    step(1'b1, 4'd3, 4'd2, 4'd5, 4'd5);
    exp_q.push_back(16'h3255);
    idle(1);
    check("t1_pending_held", 32'(pending), 32'd1);
    wait_commit(30);
    check("t1_face", 32'(face), 32'd3);
    check("t1_feed", 32'(feed_value), 32'd2);
    check("t1_pending_clear", 32'(pending), 32'd0);

    // Replacement before commit: a single overwrite pulse, only the last request lands.
    ov_cnt = 0;
    to_after_tick();
    step(1'b1, 4'd4, 4'd2, 4'd5, 4'd5);
    idle(2);
    step(1'b1, 4'd6, 4'd2, 4'd5, 4'd5);
    exp_q.push_back(16'h6255);
    wait_commit(40);
    check("t2_overwrite_cnt", 32'(ov_cnt), 32'd1);
    check("t2_face", 32'(face), 32'd6);

    // Request after every tick: commits land exactly three ticks apart.
    c0 = commit_cnt;
    begin
      logic [3:0] faces [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
      for (int k = 0; k < 7; k++) begin
        if (k > 0) to_after_tick();
        step(1'b1, faces[k], 4'd2, 4'd5, 4'd5);
        if (k == 2 || k == 5 || k == 6) exp_q.push_back({faces[k], 12'h255});
      end
    end
    wait_commit(40);
    check("t3_commit_cnt", 32'(commit_cnt - c0), 32'd3);
    n = commit_ticks.size();
    for (int i = 1; i <= 3; i++)
      check("t3_spacing", 32'(commit_ticks[n - i] - commit_ticks[n - i - 1]), 32'd3);

    // No-op request retires silently; out-of-range fields clamp.
    repeat (3) to_after_tick();
    c0 = commit_cnt;
    step(1'b1, 4'd8, 4'd2, 4'd5, 4'd5);
    idle(1);
    check("t4_pending_set", 32'(pending), 32'd1);
    to_after_tick();
    idle(1);
    check("t4_pending_clear", 32'(pending), 32'd0);
    check("t4_no_commit", 32'(commit_cnt - c0), 32'd0);
    step(1'b1, 4'd12, 4'd7, 4'd1, 4'd2);
    exp_q.push_back(16'h0512);
    wait_commit(30);
    check("t4_feed_clamp", 32'(feed_value), 32'd5);
    check("t4_face_clamp", 32'(face), 32'd0);

    // Reset while pending with hold_cnt==1.
    to_after_tick();
    step(1'b1, 4'd3, 4'd1, 4'd1, 4'd1);
    idle(1);
    check("t5_pending_set", 32'(pending), 32'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t5_rst_outputs", {16'd0, face, feed_value, joy_value, energy_value}, 32'h0555);
    check("t5_rst_pending", 32'(pending), 32'd0);
    c0 = commit_cnt;
    idle(25);
    check("t5_no_commit", 32'(commit_cnt - c0), 32'd0);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
